// File: rtl/alien_draw.sv
// alien_draw: redraws a single SPRITE_W x SPRITE_H alien on a 160x120 VGA
// framebuffer. A frame_tick accepted in IDLE captures the alien's position,
// colour and alive flag. The block then erases the sprite at its previous
// position, if one was drawn, and draws it at the new position if the alien
// is alive. It emits one pixel per cycle in raster order and finishes with a
// one-cycle done pulse.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      synchronous reset, ACTIVE HIGH despite its name
//   frame_tick   one-cycle redraw request; ignored while busy
//   x_pos/y_pos  alien top-left corner (8b / 7b)
//   colour       alien colour (3b)
//   alive        1 = erase then draw, 0 = erase only
//   vga_x/vga_y  pixel coordinate; holds its last value when plot = 0
//   vga_colour   pixel colour
//   plot         write strobe; vga_* are valid in the same cycle
//   busy         high from tick acceptance until the done cycle
//   done         one-cycle completion pulse
//   dbg_state    current FSM state (IDLE=0, ERASE=1, DRAW=2, DONE=3)
//
// Handshake: frame_tick is a request with no backpressure. It is accepted
// only when the FSM is in IDLE and is dropped otherwise. plot is a
// qualifier with no ready: the VGA adapter must accept every pixel that has
// plot = 1.
module alien_draw #(
  parameter int          SPRITE_W  = 4,
  parameter int          SPRITE_H  = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  input  logic [2:0] colour,
  input  logic       alive,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] DY_LAST = 4'(SPRITE_H - 1);

  state_t     state;
  logic [3:0] dx;
  logic [3:0] dy;

  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] new_colour;
  logic       new_alive;

  logic [7:0] prev_x;
  logic [6:0] prev_y;
  logic       prev_valid;

  // Pixel for the current slot. The sum is one bit wider than the screen
  // coordinate, so a sprite hanging off the right or bottom edge is detected
  // rather than wrapped around.
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] pix_colour;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       on_screen;
  logic       last_pix;

  always_comb begin
    base_x     = new_x;
    base_y     = new_y;
    pix_colour = new_colour;
    if (state == ERASE) begin
      base_x     = prev_x;
      base_y     = prev_y;
      pix_colour = BG_COLOUR;
    end
    pix_x     = {1'b0, base_x} + {5'd0, dx};
    pix_y     = {1'b0, base_y} + {4'd0, dy};
    on_screen = (pix_x <= 9'd159) && (pix_y <= 8'd119);
    last_pix  = (dx == DX_LAST) && (dy == DY_LAST);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= IDLE;
      dx         <= '0;
      dy         <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= '0;
      new_alive  <= 1'b0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            new_x      <= x_pos;
            new_y      <= y_pos;
            new_colour <= colour;
            new_alive  <= alive;
            busy       <= 1'b1;
            dx         <= '0;
            dy         <= '0;
            if (prev_valid)  state <= ERASE;
            else if (alive)  state <= DRAW;
            else             state <= DONE;
          end
        end

        ERASE, DRAW: begin
          // An off-screen slot still takes its cycle so that frame latency
          // does not depend on where the alien is.
          plot <= on_screen;
          if (on_screen) begin
            vga_x      <= pix_x[7:0];
            vga_y      <= pix_y[6:0];
            vga_colour <= pix_colour;
          end
          if (dx == DX_LAST) begin
            dx <= '0;
            if (dy == DY_LAST) dy <= '0;
            else               dy <= dy + 4'd1;
          end else begin
            dx <= dx + 4'd1;
          end
          if (last_pix) begin
            if (state == ERASE && new_alive) state <= DRAW;
            else                             state <= DONE;
          end
        end

        DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          prev_x     <= new_x;
          prev_y     <= new_y;
          prev_valid <= new_alive;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_draw.sv
// tb_alien_draw: randomized and directed bench for alien_draw. When a frame
// is accepted, the model writes out the whole expected output timeline for
// that frame into exp_q, one word per cycle. An empty queue means the
// outputs must be idle. Every cycle the observed outputs are checked against
// the head of the queue.
module tb_alien_draw;

  localparam int         SW = 4;
  localparam int         SH = 4;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic [2:0] colour;
  logic       alive;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  alien_draw #(.SPRITE_W(SW), .SPRITE_H(SH), .BG_COLOUR(BG)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .x_pos(x_pos), .y_pos(y_pos), .colour(colour), .alive(alive),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state: word = {plot, busy, done, x[7:0], y[6:0], colour[2:0]}
  logic [20:0] exp_q[$];
  int          vectors = 0;
  int          errors  = 0;

  // model of what the screen-side outputs and the remembered sprite are
  logic       m_valid = 1'b0;
  int         m_px = 0;
  int         m_py = 0;
  logic [7:0] m_vx = '0;
  logic [6:0] m_vy = '0;
  logic [2:0] m_vc = '0;

  // per-frame observations for the literal checks
  int         cyc;
  int         obs_plots;
  int         obs_done_at;
  logic [17:0] obs_first;
  logic [17:0] obs_last;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_pixels(input int bx, input int by, input logic [2:0] c);
    for (int dy = 0; dy < SH; dy++) begin
      for (int dx = 0; dx < SW; dx++) begin
        int px;
        int py;
        px = bx + dx;
        py = by + dy;
        if (px <= 159 && py <= 119) begin
          m_vx = 8'(px);
          m_vy = 7'(py);
          m_vc = c;
          exp_q.push_back({1'b1, 1'b1, 1'b0, m_vx, m_vy, m_vc});
        end else begin
          exp_q.push_back({1'b0, 1'b1, 1'b0, m_vx, m_vy, m_vc});
        end
      end
    end
  endtask

  task automatic model_accept(input int x, input int y, input logic [2:0] c, input logic al);
    exp_q.push_back({1'b0, 1'b1, 1'b0, m_vx, m_vy, m_vc});
    if (m_valid) push_pixels(m_px, m_py, BG);
    if (al) push_pixels(x, y, c);
    exp_q.push_back({1'b0, 1'b0, 1'b1, m_vx, m_vy, m_vc});
    m_px    = x;
    m_py    = y;
    m_valid = al;
  endtask

  // driver: applies one cycle of inputs, advances the model, then checks the
  // outputs on the following falling edge.
  task automatic step(input logic tk, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic al, input logic rst);
    logic [20:0] exp_w;
    logic [20:0] act_w;
    reset_n    = rst;
    frame_tick = tk;
    x_pos      = x;
    y_pos      = y;
    colour     = c;
    alive      = al;
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_px = 0;
      m_py = 0;
      m_vx = '0;
      m_vy = '0;
      m_vc = '0;
    end else if (tk && exp_q.size() == 0) begin
      model_accept(int'(x), int'(y), c, al);
    end
    @(negedge clk);
    cyc++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front();
    else                   exp_w = {1'b0, 1'b0, 1'b0, m_vx, m_vy, m_vc};
    act_w = {plot, busy, done, vga_x, vga_y, vga_colour};
    vectors++;
    if (act_w !== exp_w) begin
      errors++;
      $display("FAIL cycle %0d outputs: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d expected plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
               cyc, act_w[20], act_w[19], act_w[18], act_w[17:10], act_w[9:3], act_w[2:0],
               exp_w[20], exp_w[19], exp_w[18], exp_w[17:10], exp_w[9:3], exp_w[2:0]);
    end
    if (plot === 1'b1) begin
      if (obs_plots == 0) obs_first = {vga_x, vga_y, vga_colour};
      obs_last = {vga_x, vga_y, vga_colour};
      obs_plots++;
    end
    if (done === 1'b1 && obs_done_at < 0) obs_done_at = cyc;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Starts a frame (tick sampled in cycle 0) and runs until done is seen.
  // With noise set, ticks and input changes are thrown in while busy.
  task automatic run_frame(input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic al, input logic noise);
    cyc         = -1;
    obs_plots   = 0;
    obs_done_at = -1;
    obs_first   = '0;
    obs_last    = '0;
    step(1'b1, x, y, c, al, 1'b0);
    for (int i = 0; i < 80 && obs_done_at < 0; i++) begin
      if (noise)
        step(1'($urandom_range(0, 1)), 8'($urandom), 7'($urandom), 3'($urandom),
             1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'b0, x, y, c, al, 1'b0);
    end
    if (obs_done_at < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done within 80 cycles expected done");
    end
  endtask

  task automatic check_frame(input string name, input int plots, input int done_at);
    check({name, "_plots"}, obs_plots, plots);
    check({name, "_done_cycle"}, obs_done_at, done_at);
  endtask

  initial begin
    reset_n = 1'b1; frame_tick = 1'b0; x_pos = '0; y_pos = '0; colour = '0; alive = 1'b0;
    cyc = 0; obs_plots = 0; obs_done_at = -1; obs_first = '0; obs_last = '0;
    @(negedge clk);
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 8'd50, 7'd50, 3'd5, 1'b1, 1'b1);  // reset beats a tick
    check("reset_plot", int'(plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_vga", int'({vga_x, vga_y, vga_colour}), 0);
    idle_steps(2);

    // first frame: draw only
    run_frame(8'd10, 7'd20, 3'b111, 1'b1, 1'b0);
    check_frame("first", 16, 17);
    check("first_pix", int'(obs_first), int'({8'd10, 7'd20, 3'b111}));
    check("first_last", int'(obs_last), int'({8'd13, 7'd23, 3'b111}));
    idle_steps(1);

    // move by one: erase then draw, with ignored ticks in between
    run_frame(8'd11, 7'd20, 3'b111, 1'b1, 1'b1);
    check_frame("move", 32, 33);
    check("move_first", int'(obs_first), int'({8'd10, 7'd20, 3'b000}));
    check("move_last", int'(obs_last), int'({8'd14, 7'd23, 3'b111}));

    // hit: erase only, then nothing at all
    run_frame(8'd11, 7'd20, 3'b111, 1'b0, 1'b0);
    check_frame("hit", 16, 17);
    check("hit_last", int'(obs_last), int'({8'd14, 7'd23, 3'b000}));
    run_frame(8'd11, 7'd20, 3'b111, 1'b0, 1'b0);
    check_frame("empty", 0, 1);
    idle_steps(2);

    // clipping at the bottom-right corner
    run_frame(8'd158, 7'd118, 3'b010, 1'b1, 1'b0);
    check_frame("clip", 4, 17);
    check("clip_first", int'(obs_first), int'({8'd158, 7'd118, 3'b010}));
    check("clip_last", int'(obs_last), int'({8'd159, 7'd119, 3'b010}));

    // reset partway through an erase, with ticks arriving while busy
    cyc = -1;
    step(1'b1, 8'd40, 7'd30, 3'b001, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, 8'd90, 7'd90, 3'b100, 1'b1, 1'b0);
    step(1'b1, 8'd90, 7'd90, 3'b100, 1'b1, 1'b1);
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    idle_steps(3);
    run_frame(8'd40, 7'd30, 3'b001, 1'b1, 1'b0);
    check_frame("after_abort", 16, 17);

    // randomized frames, some cut short by reset
    for (int f = 0; f < 40; f++) begin
      logic [7:0] rx;
      logic [6:0] ry;
      logic [2:0] rc;
      logic       ra;
      rx = 8'($urandom_range(0, 175));
      ry = 7'($urandom_range(0, 127));
      rc = 3'($urandom);
      ra = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        step(1'b1, rx, ry, rc, ra, 1'b0);
        for (int i = 0; i < int'($urandom_range(0, 20)); i++)
          step(1'($urandom_range(0, 1)), 8'($urandom), 7'($urandom), 3'($urandom), 1'b1, 1'b0);
        step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
      end else begin
        run_frame(rx, ry, rc, ra, 1'($urandom_range(0, 1)));
      end
      idle_steps($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
